fifo_uart_tx: RTL and testbench
===============================

// Module: fifo_uart_tx
// PURPOSE
//  Read-side consumer of the async FIFO: drains words via rinc/rempty/rdata in the rclk
//  domain and serialises each as an asynchronous UART frame on tx.
//  Start bit, DSIZE data bits LSB first, optional even parity, STOP_BITS stop bits.
//  Sits directly downstream of the FIFO read port; it is the only rinc driver.
// PARAMETERS
//  DSIZE        8   data word width; matches FIFO DSIZE
//  CLKS_PER_BIT 16  rclk cycles per serial bit, >=2
//  PARITY_EN    0   1 = append even-parity bit after data
//  STOP_BITS    1   number of stop bits, 1 or 2
// PORTS
//  rclk     in   1      clock, rising edge; same clock as FIFO read side
//  rrst_n   in   1      reset, synchronous, active-low
//  en       in   1      1 = allowed to start new frames
//  rempty   in   1      FIFO empty flag
//  rdata    in   DSIZE  FIFO read data; valid whenever rempty=0
//  rinc     out  1      FIFO pop strobe, combinational
//  tx       out  1      serial line, idle high, registered
//  busy     out  1      1 while a frame is in progress, registered
//  tx_done  out  1      one-cycle pulse in last cycle of final stop bit, registered
// BEHAVIOUR
//  Reset (rrst_n=0 at rclk edge): state=IDLE, tx=1, busy=0, tx_done=0, bit/baud
//   counters=0, shift reg=0. rinc=0 while in reset.
//  rinc = (state==IDLE) & en & ~rempty & rrst_n; high for exactly one cycle per word.
//   In that cycle rdata latched into shift reg, parity computed (^rdata); next edge -> START.
//  States: IDLE -> START -> DATA -> [PARITY if PARITY_EN] -> STOP -> IDLE.
//  Each bit state holds tx constant for CLKS_PER_BIT cycles; baud counter 0..CLKS_PER_BIT-1,
//   state/bit advance when counter == CLKS_PER_BIT-1; counter reloads to 0.
//  START: tx=0. DATA: tx=shreg[0], shift right per bit, bit counter 0..DSIZE-1.
//  PARITY: tx=^data (even: total ones incl. parity bit even). STOP: tx=1 for
//   STOP_BITS*CLKS_PER_BIT cycles.
//  tx registered: changes on the edge entering each bit; first start-bit cycle is the
//   cycle after rinc. Frame = (1+DSIZE+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
//  After STOP returns to IDLE for >=1 cycle; back-to-back words: rinc period = frame+1.
//  busy=1 from cycle after rinc through last stop cycle; 0 in IDLE.
//  en=0 mid-frame: current frame completes; no new rinc until en=1.
//  rempty ignored outside IDLE; rempty=1 in IDLE -> no rinc, tx stays 1.
//  Reset mid-frame: frame aborted, tx=1 at next edge, word lost; no extra pop issued.
//  rdata not sampled except in the rinc cycle.
// TESTING
//  T1 reset: hold rrst_n=0 3 cycles, rempty=0 -> rinc=0, tx=1, busy=0, tx_done=0.
//  T2 single word: DSIZE=8, CLKS_PER_BIT=4, rdata=8'hA5 -> one rinc pulse; tx=0 4 cycles,
//     then 1,0,1,0,0,1,0,1 4 cycles each, then 1; tx_done at cycle 40 after rinc.
//  T3 back-to-back: drive FIFO with 3 words 8'h01,8'h80,8'hFF, continuous rempty=0 ->
//     rinc pulses 41 cycles apart, 3 frames decode exactly, busy low 1 cycle between.
//  T4 parity: PARITY_EN=1, rdata=8'h07 -> parity bit=1; rdata=8'h03 -> parity bit=0.
//  T5 empty/en: rempty=1 or en=0 for 100 cycles -> rinc never 1, tx=1; en drop mid-frame
//     -> frame finishes, no further rinc.
//  T6 reset mid-frame: rrst_n=0 during DATA bit 3 -> next edge tx=1, busy=0; after
//     release with rempty=0 next word popped and framed from start.

Source files
------------

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle: the async FIFO is the slave, its single reader is the master.
interface fifo_uart_tx_if #(
    parameter int unsigned DSIZE = 8
);
    logic             rinc;
    logic             rempty;
    logic [DSIZE-1:0] rdata;

    modport master (output rinc, input rempty, input rdata);
    modport slave  (input rinc, output rempty, output rdata);
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains the async FIFO read port and serialises each word as a UART frame:
// start bit, DSIZE data bits LSB first, optional even parity, STOP_BITS stop bits.
module fifo_uart_tx #(
    parameter int unsigned DSIZE        = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic           rclk,
    input  logic           rrst_n,
    input  logic           en,
    fifo_uart_tx_if.master rd,
    output logic           tx,
    output logic           busy,
    output logic           tx_done
);
    localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned CW = $clog2(DSIZE + 1);

    localparam logic [BW-1:0] BaudLast = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BaudPen  = BW'(CLKS_PER_BIT - 2);
    localparam logic [CW-1:0] BitLast  = CW'(DSIZE - 1);
    localparam logic [CW-1:0] StopLast = CW'(STOP_BITS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [BW-1:0]    baud_q, baud_d;
    logic [CW-1:0]    bit_q, bit_d;
    logic [DSIZE-1:0] shreg_q, shreg_d;
    logic             par_q, par_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             baud_end;
    logic             rinc;

    // Pop only from IDLE; gating with rrst_n keeps a reset cycle from losing a word.
    assign rinc     = (state_q == ST_IDLE) && en && !rd.rempty && rrst_n;
    assign rd.rinc  = rinc;
    assign baud_end = (baud_q == BaudLast);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (state_q != ST_IDLE) begin
            baud_d = baud_end ? '0 : baud_q + BW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (rinc) begin
                    shreg_d = rd.rdata;
                    par_d   = ^rd.rdata;
                    state_d = ST_START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            ST_START: begin
                if (baud_end) begin
                    state_d = ST_DATA;
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    if (bit_q == BitLast) begin
                        bit_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = ST_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + CW'(1);
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (baud_end) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                // Registered pulse must land in the final stop cycle, so arm it one cycle early.
                done_d = (bit_q == StopLast) && (baud_q == BaudPen);
                if (baud_end) begin
                    if (bit_q == StopLast) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign tx_done = done_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Two DUT lanes (8N1 at 4 clk/bit, 8E2 at 3 clk/bit) checked every cycle against a
// waveform-queue model: each pop appends the whole expected tx frame, one entry per cycle.
module tb_fifo_uart_tx;
    localparam int unsigned NLanes = 2;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic en       = 1'b0;
    logic empty_in = 1'b0;
    bit   checking = 1'b0;
    int   n_chk    = 0;
    int   n_err    = 0;
    logic [7:0] dir_words [6] = '{8'hA5, 8'h01, 8'h80, 8'hFF, 8'h07, 8'h03};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < NLanes; g++) begin : g_lane
        localparam int unsigned Cpb   = 4 - g;
        localparam int unsigned Par   = g;
        localparam int unsigned Stops = 1 + g;

        fifo_uart_tx_if #(.DSIZE(8)) fif ();
        logic       tx;
        logic       busy;
        logic       tx_done;
        logic       exp_rinc;
        logic [7:0] cur_word = 8'hA5;
        int         widx     = 0;
        bit         wave[$];

        assign fif.rempty = empty_in;

        fifo_uart_tx #(
            .DSIZE       (8),
            .CLKS_PER_BIT(Cpb),
            .PARITY_EN   (Par),
            .STOP_BITS   (Stops)
        ) u_dut (
            .rclk   (clk),
            .rrst_n (rst_n),
            .en     (en),
            .rd     (fif.master),
            .tx     (tx),
            .busy   (busy),
            .tx_done(tx_done)
        );

        always @(negedge clk) begin
            if (checking) begin
                exp_rinc  = (wave.size() == 0) && en && !empty_in && rst_n;
                // Head word only matters when a pop can happen; junk otherwise.
                fif.rdata = (wave.size() == 0) ? cur_word : 8'($urandom);
                check($sformatf("lane%0d rinc", g), 8'(fif.rinc), 8'(exp_rinc));
                check($sformatf("lane%0d tx", g), 8'(tx),
                      (wave.size() != 0) ? 8'(wave[0]) : 8'd1);
                check($sformatf("lane%0d busy", g), 8'(busy), 8'(wave.size() != 0));
                check($sformatf("lane%0d tx_done", g), 8'(tx_done), 8'(wave.size() == 1));
                if (!rst_n) begin
                    wave.delete();
                end else begin
                    if (wave.size() != 0) void'(wave.pop_front());
                    if (exp_rinc) begin
                        repeat (Cpb) wave.push_back(1'b0);
                        for (int b = 0; b < 8; b++) repeat (Cpb) wave.push_back(cur_word[b]);
                        if (Par != 0) repeat (Cpb) wave.push_back(^cur_word);
                        repeat (Stops * Cpb) wave.push_back(1'b1);
                        widx++;
                        cur_word = (widx < 6) ? dir_words[widx] : 8'($urandom);
                    end
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        en       = 1'b1;
        empty_in = 1'b0;
        @(posedge clk);
        #1 checking = 1'b1;
        run(2);
        rst_n = 1'b1;

        // Directed words back-to-back, then empty and disabled stretches.
        run(250);
        empty_in = 1'b1;
        run(100);
        empty_in = 1'b0;
        en       = 1'b0;
        run(100);
        en = 1'b1;
        run(10);
        en = 1'b0;
        run(100);

        // Reset in lane 0 data bit 3: pop happens in the first enabled cycle.
        en = 1'b1;
        run(18);
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        run(200);

        for (int i = 0; i < 2000; i++) begin
            en       = ($urandom_range(0, 7) != 0);
            empty_in = ($urandom_range(0, 4) == 0);
            rst_n    = ($urandom_range(0, 399) != 0);
            run(1);
        end
        rst_n = 1'b1;
        en    = 1'b0;
        run(60);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
